// File: rtl/hazard_scoreboard_if.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard_if
// Bundles the pipeline-side signals of the hazard scoreboard.
//   master : pipeline side. Drives register ids, write/load flags, branch and
//            MDU start flags. Receives stall/flush/forward controls, MDU
//            status and the stall-cycle counter.
//   slave  : scoreboard side (hazard_scoreboard).
// ----------------------------------------------------------------------------
interface hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    // Decode / Execute sources, E/M/W destinations
    logic [REG_AW-1:0] RsD, RtD, RsE, RtE;
    logic [REG_AW-1:0] WriteRegE, WriteRegM, WriteRegW;
    logic              RegWriteE, RegWriteM, RegWriteW;
    logic              MemtoRegE, MemtoRegM;
    logic              BranchD, PCSrcD;
    logic              MduStartD, MduStartE;

    // Pipeline control back to the datapath
    logic              StallF, StallD, FlushD, FlushE;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              ForwardAD, ForwardBD;
    logic              MduBusy, MduDone;
    logic [CNT_W-1:0]  StallCycles;

    modport master (
        output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, PCSrcD, MduStartD, MduStartE,
        input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
               ForwardAD, ForwardBD, MduBusy, MduDone, StallCycles
    );

    modport slave (
        input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
               RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
               BranchD, PCSrcD, MduStartD, MduStartE,
        output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE,
               ForwardAD, ForwardBD, MduBusy, MduDone, StallCycles
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard
// Hazard unit for a 5-stage pipeline with a multi-cycle multiply/divide unit.
// Produces operand forwarding selects for the E-stage ALU and the D-stage
// branch comparator, detects load-use, branch and MDU hazards, stalls F/D and
// flushes E on a hazard, flushes D on a taken branch/jump, tracks MDU
// occupancy and counts stalled Decode cycles (saturating).
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   hz     : hazard_scoreboard_if.slave (all pipeline-side signals)
//
// Register 0 never matches, so it never forwards or stalls.
// MDU_LAT must lie in 2..15 (the busy counter is 4 bits).
// ----------------------------------------------------------------------------

// Per-operand slice: one instance for the A (Rs) operand, one for B (Rt).
// Works out forwarding for the operand and which producers the D-stage
// source of that operand depends on.
module hazard_scoreboard_lane #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] srcD,
    input  logic [REG_AW-1:0] srcE,
    input  logic [REG_AW-1:0] writeRegE,
    input  logic [REG_AW-1:0] writeRegM,
    input  logic [REG_AW-1:0] writeRegW,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] mduDest,
    input  logic              regWriteM,
    input  logic              regWriteW,
    output logic [1:0]        fwdE,
    output logic              fwdD,
    output logic              hitWriteE,
    output logic              hitWriteM,
    output logic              hitRtE,
    output logic              hitMduDest
);
    function automatic logic match(input logic [REG_AW-1:0] x,
                                   input logic [REG_AW-1:0] r);
        return (r != '0) && (x == r);
    endfunction

    // M is younger than W, so its result wins.
    always_comb begin
        fwdE = 2'b00;
        if (regWriteM && match(writeRegM, srcE))
            fwdE = 2'b10;
        else if (regWriteW && match(writeRegW, srcE))
            fwdE = 2'b01;
    end

    assign fwdD       = regWriteM && match(writeRegM, srcD);
    assign hitWriteE  = match(writeRegE, srcD);
    assign hitWriteM  = match(writeRegM, srcD);
    assign hitRtE     = match(rtE, srcD);
    assign hitMduDest = match(mduDest, srcD);
endmodule

module hazard_scoreboard #(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input logic             clk,
    input logic             rst_n,
    hazard_scoreboard_if.slave hz
);
    localparam int         NUM_OPS  = 2;  // lane 0 = A (Rs), lane 1 = B (Rt)
    localparam logic [3:0] CNT_LOAD = 4'(MDU_LAT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mduState_t;

    mduState_t         state;
    logic [3:0]        cnt;
    logic [REG_AW-1:0] mduDestR;
    logic              mduBusyR;
    logic              mduDoneR;
    logic [CNT_W-1:0]  stallCnt;

    logic [NUM_OPS-1:0][REG_AW-1:0] srcD, srcE;
    logic [NUM_OPS-1:0][1:0]        fwdE;
    logic [NUM_OPS-1:0]             fwdD;
    logic [NUM_OPS-1:0]             hitWriteE, hitWriteM, hitRtE, hitMduDest;

    logic mduActive;
    logic mduInBusy;
    logic lwStall, brStall, mduStall, stall;

    assign srcD = {hz.RtD, hz.RsD};
    assign srcE = {hz.RtE, hz.RsE};

    generate
        for (genvar i = 0; i < NUM_OPS; i++) begin : gLane
            hazard_scoreboard_lane #(.REG_AW(REG_AW)) uLane (
                .srcD      (srcD[i]),
                .srcE      (srcE[i]),
                .writeRegE (hz.WriteRegE),
                .writeRegM (hz.WriteRegM),
                .writeRegW (hz.WriteRegW),
                .rtE       (hz.RtE),
                .mduDest   (mduDestR),
                .regWriteM (hz.RegWriteM),
                .regWriteW (hz.RegWriteW),
                .fwdE      (fwdE[i]),
                .fwdD      (fwdD[i]),
                .hitWriteE (hitWriteE[i]),
                .hitWriteM (hitWriteM[i]),
                .hitRtE    (hitRtE[i]),
                .hitMduDest(hitMduDest[i])
            );
        end
    endgenerate

    // While reset is held the MDU is treated as idle, so the MDU stall terms
    // never depend on state that is about to be cleared.
    assign mduActive = rst_n && (state != IDLE);
    assign mduInBusy = rst_n && (state == BUSY);

    assign lwStall = hz.MemtoRegE && (|hitRtE);

    // A branch resolves in D, so it must wait for an ALU result still in E
    // or for load data still in M.
    assign brStall = hz.BranchD &&
                     ((hz.RegWriteE && (|hitWriteE)) ||
                      (hz.MemtoRegM && (|hitWriteM)));

    // MDU hazards: consumer of an MDU op being launched, consumer of the op
    // in flight, or a second MDU op while the unit is occupied / launching.
    assign mduStall = (hz.MduStartE && (|hitWriteE)) ||
                      (mduActive && (|hitMduDest)) ||
                      (hz.MduStartD && (mduInBusy || hz.MduStartE));

    assign stall = lwStall || brStall || mduStall;

    assign hz.StallF      = stall;
    assign hz.StallD      = stall;
    assign hz.FlushE      = stall;
    assign hz.FlushD      = hz.PCSrcD && !stall;
    assign hz.ForwardAE   = fwdE[0];
    assign hz.ForwardBE   = fwdE[1];
    assign hz.ForwardAD   = fwdD[0];
    assign hz.ForwardBD   = fwdD[1];
    assign hz.MduBusy     = mduBusyR;
    assign hz.MduDone     = mduDoneR;
    assign hz.StallCycles = stallCnt;

    // MDU occupancy FSM. BUSY runs MDU_LAT cycles (cnt counts MDU_LAT-1..0),
    // then DONE for one cycle. A start seen in DONE relaunches directly.
    // Starts seen in BUSY are dropped. Busy/done flags are registered
    // alongside the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            mduDestR <= '0;
            mduBusyR <= 1'b0;
            mduDoneR <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hz.MduStartE) begin
                        state    <= BUSY;
                        cnt      <= CNT_LOAD;
                        mduDestR <= hz.WriteRegE;
                        mduBusyR <= 1'b1;
                    end
                    mduDoneR <= 1'b0;
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state    <= DONE;
                        mduDoneR <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    mduDoneR <= 1'b0;
                    if (hz.MduStartE) begin
                        state    <= BUSY;
                        cnt      <= CNT_LOAD;
                        mduDestR <= hz.WriteRegE;
                    end else begin
                        state    <= IDLE;
                        mduBusyR <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    mduBusyR <= 1'b0;
                    mduDoneR <= 1'b0;
                end
            endcase
        end
    end

    // Stalled-Decode counter, sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n)
            stallCnt <= '0;
        else if (stall && (stallCnt != {CNT_W{1'b1}}))
            stallCnt <= stallCnt + CNT_W'(1);
    end
endmodule
